// File: rtl/pq_pkg.sv
// Shared QuickQ types: key/value entry, host command opcodes, response codes and
// host-interface FSM states.
package pq_pkg;

   localparam int unsigned PQ_W = 32;

   typedef struct packed {
      logic [PQ_W-1:0] key;
      logic [PQ_W-1:0] val;
   } kv_t;

   typedef enum logic [1:0] {
      OP_ENQ  = 2'b00,
      OP_DEQ  = 2'b01,
      OP_REPL = 2'b10,
      OP_PEEK = 2'b11
   } qq_op_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_FULL    = 2'b01,
      ERR_EMPTY   = 2'b10,
      ERR_TIMEOUT = 2'b11
   } qq_err_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_WAIT,
      ST_RESP
   } qq_state_t;

endpackage

// File: rtl/qq_host_if.sv
// Host-side command initiator for the QuickQ node chain: issues single-cycle
// commands to node 0, waits for completion, returns a response, tracks occupancy.
module qq_host_if
   import pq_pkg::*;
#(
   parameter int unsigned W       = 32,
   parameter int unsigned CAP     = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  qq_op_t                     cmd_op,
   input  kv_t                        cmd_kv,
   input  logic                       q_rdy,
   input  logic                       q_full,
   input  logic                       q_empty,
   input  kv_t                        q_head,
   output logic                       q_enq,
   output logic                       q_deq,
   output logic                       q_repl,
   output kv_t                        q_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output kv_t                        rsp_kv,
   output qq_err_t                    rsp_err,
   output logic [$clog2(CAP+1)-1:0]   count
);

   localparam int unsigned CW   = $clog2(CAP + 1);
   localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   if (W != PQ_W) begin : g_w_check
      $error("qq_host_if: W must match the node chain key width PQ_W");
   end

   qq_state_t         state_q, state_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [CW-1:0]     count_q, count_d;
   qq_op_t            op_q, op_d;
   kv_t               rsp_kv_q, rsp_kv_d;
   qq_err_t           rsp_err_q, rsp_err_d;
   logic              full, empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wdog_q    <= '0;
         count_q   <= '0;
         op_q      <= OP_ENQ;
         rsp_kv_q  <= '0;
         rsp_err_q <= ERR_OK;
      end else begin
         state_q   <= state_d;
         wdog_q    <= wdog_d;
         count_q   <= count_d;
         op_q      <= op_d;
         rsp_kv_q  <= rsp_kv_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wdog_d    = wdog_q;
      count_d   = count_q;
      op_d      = op_q;
      rsp_kv_d  = rsp_kv_q;
      rsp_err_d = rsp_err_q;
      cmd_ready = 1'b0;
      q_enq     = 1'b0;
      q_deq     = 1'b0;
      q_repl    = 1'b0;
      q_data    = '0;
      // Local occupancy backs up the chain flags so a stale flag cannot overrun.
      full      = q_full | (count_q == CW'(CAP));
      empty     = q_empty | (count_q == '0);

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = q_rdy & ~rst;
            if (cmd_valid && cmd_ready) begin
               op_d      = cmd_op;
               rsp_kv_d  = '0;
               rsp_err_d = ERR_OK;
               case (cmd_op)
                  OP_ENQ: begin
                     if (full) begin
                        rsp_err_d = ERR_FULL;
                        state_d   = ST_RESP;
                     end else begin
                        q_enq   = 1'b1;
                        q_data  = cmd_kv;
                        state_d = ST_HOLD;
                     end
                  end
                  OP_DEQ: begin
                     if (empty) begin
                        rsp_err_d = ERR_EMPTY;
                        state_d   = ST_RESP;
                     end else begin
                        q_deq    = 1'b1;
                        rsp_kv_d = q_head;
                        state_d  = ST_HOLD;
                     end
                  end
                  OP_REPL: begin
                     if (empty) begin
                        rsp_err_d = ERR_EMPTY;
                        state_d   = ST_RESP;
                     end else begin
                        q_repl   = 1'b1;
                        q_data   = cmd_kv;
                        rsp_kv_d = q_head;
                        state_d  = ST_HOLD;
                     end
                  end
                  default: begin
                     rsp_kv_d  = q_head;
                     rsp_err_d = empty ? ERR_EMPTY : ERR_OK;
                     state_d   = ST_RESP;
                  end
               endcase
            end
         end
         // The node drops rdy one cycle after the pulse, so rdy is not trusted here.
         ST_HOLD: begin
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wdog_d = wdog_q + 1'b1;
            if (q_rdy) begin
               state_d   = ST_RESP;
               rsp_err_d = ERR_OK;
               if (op_q == OP_ENQ && count_q != CW'(CAP)) begin
                  count_d = count_q + 1'b1;
               end else if (op_q == OP_DEQ && count_q != '0) begin
                  count_d = count_q - 1'b1;
               end
            end else if (wdog_q == WD_W'(TIMEOUT - 2)) begin
               state_d   = ST_RESP;
               rsp_err_d = ERR_TIMEOUT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_kv    = rsp_kv_q;
   assign rsp_err   = rsp_err_q;
   assign count     = count_q;

endmodule
